// File: rtl/fifo_uram_ctrl.sv
// fifo_uram_ctrl
// Controller that turns a simple dual-port URAM core into a first-word-fall-through
// stream FIFO. The core has write port 0 and read port 1, and its read data is
// registered, so it arrives one cycle after the read is issued. A two-entry output
// buffer (head + skid) hides that read latency. This lets back-to-back pops sustain
// one word per cycle.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   if_din, if_write    producer side; a write is accepted while if_full_n = 1
//   if_full_n           memory has space (reflects memory occupancy only)
//   if_dout, if_empty_n head word and its valid flag
//   if_read             consumer pop; effective while if_empty_n = 1
//   mem_address0/ce0/we0/d0   memcore write port
//   mem_address1/ce1          memcore read port
//   mem_q1                    memcore read data, valid the cycle after mem_ce1
module fifo_uram_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6,
  parameter int DEPTH         = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    if_din,
  input  logic                     if_write,
  output logic                     if_full_n,
  output logic [DATA_WIDTH-1:0]    if_dout,
  output logic                     if_empty_n,
  input  logic                     if_read,
  output logic [ADDRESS_WIDTH-1:0] mem_address0,
  output logic                     mem_ce0,
  output logic                     mem_we0,
  output logic [DATA_WIDTH-1:0]    mem_d0,
  output logic [ADDRESS_WIDTH-1:0] mem_address1,
  output logic                     mem_ce1,
  input  logic [DATA_WIDTH-1:0]    mem_q1
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]            FULL_COUNT = CW'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]            mem_count;
  logic                     inflight;
  logic [DATA_WIDTH-1:0]    head;
  logic [DATA_WIDTH-1:0]    skid;
  logic [1:0]               out_count;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] occ_after_pop;
  logic [1:0] kept;

  // The depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [ADDRESS_WIDTH-1:0] ptr_next(input logic [ADDRESS_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDRESS_WIDTH'(1);
  endfunction

  assign push = if_write & if_full_n;
  assign pop  = if_read & if_empty_n;

  // Buffered words plus the read in flight, after this cycle's pop. A new read
  // is issued only if its data is guaranteed a slot when it returns.
  assign occ_after_pop = {1'b0, out_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue         = (mem_count != '0) & (occ_after_pop < 3'd2);
  assign kept          = out_count - {1'b0, pop};

  assign mem_ce0      = push;
  assign mem_we0      = push;
  assign mem_address0 = wr_ptr;
  assign mem_d0       = if_din;
  assign mem_ce1      = issue;
  assign mem_address1 = rd_ptr;

  assign if_full_n  = (mem_count != FULL_COUNT);
  assign if_empty_n = (out_count != 2'd0);
  assign if_dout    = head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
      head      <= '0;
      skid      <= '0;
      out_count <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ptr_next(wr_ptr);
      if (issue)
        rd_ptr <= ptr_next(rd_ptr);

      case ({push, issue})
        2'b10:   mem_count <= mem_count + CW'(1);
        2'b01:   mem_count <= mem_count - CW'(1);
        default: mem_count <= mem_count;
      endcase

      inflight <= issue;

      if (pop && (out_count == 2'd2))
        head <= skid;

      // Returning data lands in the first slot that is free once the pop is applied.
      if (inflight) begin
        if (kept == 2'd0)
          head <= mem_q1;
        else
          skid <= mem_q1;
      end

      out_count <= kept + {1'b0, inflight};
    end
  end

endmodule

// File: tb/tb_fifo_uram_ctrl.sv
// Testbench for fifo_uram_ctrl. It runs two instances, DEPTH=64 and DEPTH=48, side
// by side on shared stimulus. Each instance has a behavioural memcore model and a
// reference queue that tracks FIFO contents and the address sequences.
module tb_fifo_uram_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_write = 1'b0;
  logic        if_read = 1'b0;
  logic [31:0] if_din = '0;

  logic        full_n  [2];
  logic        empty_n [2];
  logic [31:0] dout    [2];
  logic [5:0]  a0      [2];
  logic        ce0     [2];
  logic        we0     [2];
  logic [31:0] d0      [2];
  logic [5:0]  a1      [2];
  logic        ce1     [2];
  logic [31:0] q1      [2];

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];

  always #5 clk = ~clk;

  fifo_uram_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6), .DEPTH(64)) u64 (
    .clk(clk), .reset(reset), .if_din(if_din), .if_write(if_write),
    .if_full_n(full_n[0]), .if_dout(dout[0]), .if_empty_n(empty_n[0]), .if_read(if_read),
    .mem_address0(a0[0]), .mem_ce0(ce0[0]), .mem_we0(we0[0]), .mem_d0(d0[0]),
    .mem_address1(a1[0]), .mem_ce1(ce1[0]), .mem_q1(q1[0]));

  fifo_uram_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6), .DEPTH(48)) u48 (
    .clk(clk), .reset(reset), .if_din(if_din), .if_write(if_write),
    .if_full_n(full_n[1]), .if_dout(dout[1]), .if_empty_n(empty_n[1]), .if_read(if_read),
    .mem_address0(a0[1]), .mem_ce0(ce0[1]), .mem_we0(we0[1]), .mem_d0(d0[1]),
    .mem_address1(a1[1]), .mem_ce1(ce1[1]), .mem_q1(q1[1]));

  // Memcore models: write port 0, one-cycle registered read on port 1.
  always @(posedge clk) begin
    if (ce0[0] && we0[0]) mem_a[a0[0]] <= d0[0];
    if (ce1[0]) q1[0] <= mem_a[a1[0]];
    if (ce0[1] && we0[1]) mem_b[a0[1]] <= d0[1];
    if (ce1[1]) q1[1] <= mem_b[a1[1]];
  end

  int checks = 0;
  int errors = 0;

  // Reference state per instance: words written, reads issued, words popped.
  int          wcnt   [2];
  int          rcnt   [2];
  int          pcnt   [2];
  int          starve [2];
  logic [31:0] rdat   [2][1024];

  function automatic int dep(input int d);
    return (d == 0) ? 64 : 48;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      wcnt[d] = 0; rcnt[d] = 0; pcnt[d] = 0; starve[d] = 0;
    end
  endtask

  // Called once per cycle with inputs stable, before the active edge.
  task automatic model_cycle();
    for (int d = 0; d < 2; d++) begin
      bit acc;
      int size;
      string s;
      s = (d == 0) ? "d64" : "d48";
      acc  = if_write && full_n[d];
      size = wcnt[d] - pcnt[d];
      chk({s, " we0"}, 64'(we0[d]), 64'(acc));
      chk({s, " ce0"}, 64'(ce0[d]), 64'(acc));
      if (acc) begin
        chk({s, " addr0"}, 64'(a0[d]), 64'(wcnt[d] % dep(d)));
        chk({s, " d0"}, 64'(d0[d]), 64'(if_din));
      end
      chk({s, " full_n"}, 64'(full_n[d]), 64'((wcnt[d] - rcnt[d]) != dep(d)));
      if (ce1[d]) begin
        chk({s, " addr1"}, 64'(a1[d]), 64'(rcnt[d] % dep(d)));
        chk({s, " read_of_written"}, 64'(rcnt[d] < wcnt[d]), 64'(1));
        rcnt[d]++;
      end
      if (empty_n[d]) begin
        chk({s, " empty_n_with_data"}, 64'(size > 0), 64'(1));
        if (size > 0)
          chk({s, " dout"}, 64'(dout[d]), 64'(rdat[d][pcnt[d] % 1024]));
        starve[d] = 0;
      end else if (size > 0) begin
        starve[d]++;
        chk({s, " head_latency"}, 64'(starve[d] <= 2), 64'(1));
      end
      if (if_read && empty_n[d]) pcnt[d]++;
      chk({s, " buffer_bound"}, 64'((rcnt[d] - pcnt[d]) <= 2), 64'(1));
      if (acc) begin
        rdat[d][wcnt[d] % 1024] = if_din;
        wcnt[d]++;
      end
      chk({s, " capacity"}, 64'((wcnt[d] - pcnt[d]) <= dep(d) + 2), 64'(1));
    end
  endtask

  task automatic step(input bit wr, input logic [31:0] din, input bit rd);
    @(negedge clk);
    if_write = wr;
    if_din   = din;
    if_read  = rd;
    #2;
    model_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    if_write = 1'b0;
    if_read  = 1'b0;
    reset    = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset full_n", 64'(full_n[d]), 64'(1));
      chk("reset empty_n", 64'(empty_n[d]), 64'(0));
      chk("reset dout", 64'(dout[d]), 64'(0));
      chk("reset ce0/we0/ce1", 64'({ce0[d], we0[d], ce1[d]}), 64'(0));
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] din;
    bit          rd;
    bit          e_we0;
    logic [5:0]  e_a0;
    bit          e_ce1;
    logic [5:0]  e_a1;
    bit          e_empty_n;
    logic [31:0] e_dout;
    bit          e_full_n;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int base_mc [2];

    vecs[0]  = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0,        1'b1};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 32'h0,        1'b1};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0,        1'b1};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 32'hA5A5A5A5, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 32'hA5A5A5A5, 1'b1};
    vecs[5]  = '{1'b1, 32'h12345678, 1'b0, 1'b1, 6'd1, 1'b0, 6'd0, 1'b0, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 6'd0, 1'b1, 6'd1, 1'b0, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 32'h12345678, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 32'h12345678, 1'b1};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0,        1'b1};

    for (int i = 0; i < 64; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    q1[0] = '0;
    q1[1] = '0;
    model_reset();

    // Reset values and exact single-word latency, checked against the table.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].wr, vecs[i].din, vecs[i].rd);
      chk($sformatf("vec%0d we0", i), 64'(we0[0]), 64'(vecs[i].e_we0));
      if (vecs[i].e_we0) chk($sformatf("vec%0d addr0", i), 64'(a0[0]), 64'(vecs[i].e_a0));
      chk($sformatf("vec%0d ce1", i), 64'(ce1[0]), 64'(vecs[i].e_ce1));
      if (vecs[i].e_ce1) chk($sformatf("vec%0d addr1", i), 64'(a1[0]), 64'(vecs[i].e_a1));
      chk($sformatf("vec%0d empty_n", i), 64'(empty_n[0]), 64'(vecs[i].e_empty_n));
      if (vecs[i].e_empty_n) chk($sformatf("vec%0d dout", i), 64'(dout[0]), 64'(vecs[i].e_dout));
      chk($sformatf("vec%0d full_n", i), 64'(full_n[0]), 64'(vecs[i].e_full_n));
    end

    // Capacity: DEPTH + 2 words accepted with reads held low; the next push is dropped.
    do_reset();
    for (int i = 0; i < 67; i++) begin
      step(1'b1, 32'h1000 + 32'(i), 1'b0);
      if (i == 66) chk("d64 67th push full_n", 64'(full_n[0]), 64'(0));
    end
    chk("d64 accepted", 64'(wcnt[0]), 64'(66));
    chk("d48 accepted", 64'(wcnt[1]), 64'(50));
    for (int i = 0; i < 72; i++) step(1'b0, '0, 1'b1);
    chk("d64 drained", 64'(pcnt[0]), 64'(66));
    chk("d48 drained", 64'(pcnt[1]), 64'(50));

    // Reset with a read in flight: no stale word may appear afterwards.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD0000 + 32'(i), 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0);
      chk("post-reset empty_n d64", 64'(empty_n[0]), 64'(0));
      chk("post-reset empty_n d48", 64'(empty_n[1]), 64'(0));
    end

    // Sequential stream with continuous reads: order and 47->0 wrap on the 48-deep core.
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 32'(i), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    chk("d48 stream popped", 64'(pcnt[1]), 64'(200));
    chk("d48 read wrapped", 64'(rcnt[1] > 48), 64'(1));

    // Steady state: one push and one pop every cycle, memory occupancy constant.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, $urandom, 1'b1);
      if (i == 5) begin
        base_mc[0] = wcnt[0] - rcnt[0];
        base_mc[1] = wcnt[1] - rcnt[1];
      end
      if (i >= 5) begin
        for (int d = 0; d < 2; d++) begin
          chk("steady pop", 64'(empty_n[d]), 64'(1));
          chk("steady mem_count", 64'(wcnt[d] - rcnt[d]), 64'(base_mc[d]));
        end
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Random traffic against the reference queues, alternating fill and drain bias.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      bit fill;
      fill = ((i / 400) % 2) == 0;
      step(($urandom_range(0, 99) < (fill ? 80 : 35)),
           $urandom,
           ($urandom_range(0, 99) < (fill ? 30 : 85)));
    end
    for (int i = 0; i < 80; i++) step(1'b0, '0, 1'b1);
    chk("d64 random drained", 64'(pcnt[0]), 64'(wcnt[0]));
    chk("d48 random drained", 64'(pcnt[1]), 64'(wcnt[1]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
